// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: accepts word reads/writes, posts writes through a
// small FIFO that drains into a single-port array, and forwards buffered data to reads.
module dmem_responder #(
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int WBUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        err_misalign_o,
  output logic        busy_o
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W     = $clog2(WBUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] WB_FULL = CNT_W'(WBUF_DEPTH);
  localparam logic [3:0]       LAT_M1  = 4'(RD_LAT - 1);

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         rd_cnt_q, rd_cnt_d;
  logic               ready_en_q;
  logic               rsp_fire;
  logic               rsp_valid_q;
  logic               err_q;
  logic [31:0]        last_rdata_q;
  logic [31:0]        resp_data;

  logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0]   wb_slot;
  logic [ADDR_W-1:0]  wb_idx  [WBUF_DEPTH];
  logic [31:0]        wb_data [WBUF_DEPTH];
  logic               wb_push, wb_pop;

  logic [ADDR_W-1:0]  req_idx;
  logic               misal, accept, rd_acc, wr_acc;
  logic               fwd_hit;
  logic [31:0]        fwd_data;

  logic [31:0]        mem [MEM_DEPTH];
  logic [31:0]        mem_rd_q;
  logic               fwd_hit_q;
  logic [31:0]        fwd_data_q;
  logic               rd_misal_q;

  // Upper address bits are intentionally ignored so the array aliases.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  assign req_idx = req_addr_i[ADDR_W+1:2];
  assign misal   = (req_addr_i[1:0] != 2'b00);
  assign accept  = req_valid_i & req_ready_o;
  assign rd_acc  = accept & ~req_write_i;
  assign wr_acc  = accept & req_write_i;

  assign req_ready_o = ready_en_q & (state_q == IDLE) & (wb_cnt_q < WB_FULL);

  // The array port is free on any edge that is not accepting a read.
  assign wb_push = wr_acc & ~misal;
  assign wb_pop  = ~rd_acc & (wb_cnt_q != '0);
  assign wb_slot = wb_pop ? (wb_cnt_q - CNT_W'(1)) : wb_cnt_q;

  always_comb begin
    wb_cnt_d = wb_cnt_q;
    unique case ({wb_push, wb_pop})
      2'b10:   wb_cnt_d = wb_cnt_q + CNT_W'(1);
      2'b01:   wb_cnt_d = wb_cnt_q - CNT_W'(1);
      default: wb_cnt_d = wb_cnt_q;
    endcase
  end

  // Shift-register FIFO: entry 0 is the oldest, higher entries are newer.
  for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_wb
    logic [ADDR_W-1:0] idx_q, idx_d, up_idx;
    logic [31:0]       data_q, data_d, up_data;

    if (gi == WBUF_DEPTH - 1) begin : g_top
      assign up_idx  = idx_q;
      assign up_data = data_q;
    end else begin : g_mid
      assign up_idx  = wb_idx[gi+1];
      assign up_data = wb_data[gi+1];
    end

    always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (wb_pop) begin
        idx_d  = up_idx;
        data_d = up_data;
      end
      if (wb_push && (wb_slot == CNT_W'(gi))) begin
        idx_d  = req_idx;
        data_d = req_wdata_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        idx_q  <= '0;
        data_q <= '0;
      end else begin
        idx_q  <= idx_d;
        data_q <= data_d;
      end
    end

    assign wb_idx[gi]  = idx_q;
    assign wb_data[gi] = data_q;
  end

  // Later matches override earlier ones, so the newest buffered write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CNT_W'(i) < wb_cnt_q) && (wb_idx[i] == req_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wb_pop) begin
      mem[wb_idx[0]] <= wb_data[0];
    end
    if (rd_acc) begin
      mem_rd_q <= mem[req_idx];
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rsp_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (RD_LAT == 1) begin
            rsp_fire = 1'b1;
          end else begin
            state_d  = RD_WAIT;
            rd_cnt_d = LAT_M1;
          end
        end
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q == 4'd1) begin
          state_d  = IDLE;
          rsp_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = rd_misal_q ? 32'h0 : (fwd_hit_q ? fwd_data_q : mem_rd_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      ready_en_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      last_rdata_q <= '0;
      wb_cnt_q     <= '0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
      rd_misal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      ready_en_q  <= 1'b1;
      rsp_valid_q <= rsp_fire;
      err_q       <= accept & misal;
      wb_cnt_q    <= wb_cnt_d;
      if (rsp_valid_q) begin
        last_rdata_q <= resp_data;
      end
      if (rd_acc) begin
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
        rd_misal_q <= misal;
      end
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_valid_q ? resp_data : last_rdata_q;
  assign err_misalign_o = err_q;
  assign busy_o         = (state_q != IDLE) | (wb_cnt_q != '0) | ((RD_LAT == 1) & rsp_valid_q);

endmodule
